// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: keeps the last PAT_LEN qualified bits of x and
// flags a Moore-style match against each of NUM_PAT constant patterns.
// The match counter counts match events and saturates. Non-overlapping mode
// restarts the fill count after a match. Synchronous clear is provided.
module seq_pattern_detector #(
   parameter int                          PAT_LEN  = 3,
   parameter int                          NUM_PAT  = 2,
   parameter logic [NUM_PAT*PAT_LEN-1:0]  PATTERNS = {3'b110, 3'b001},
   parameter int                          CNT_W    = 8,
   parameter int                          FILL_W   = $clog2(PAT_LEN + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                x,
   input  logic                x_valid,
   input  logic                overlap,
   input  logic                clr,
   output logic                y,
   output logic [NUM_PAT-1:0]  match_vec,
   output logic [CNT_W-1:0]    match_cnt,
   output logic [PAT_LEN-1:0]  hist,
   output logic [FILL_W-1:0]   fill
);

   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   logic [PAT_LEN-1:0] hist_nxt;
   logic [FILL_W-1:0]  fill_nxt;
   logic [CNT_W-1:0]   cnt_nxt;

   // A window matches only once it holds PAT_LEN valid bits, so an all-zero
   // pattern cannot fire on the zeroed history left by reset or clr.
   function automatic logic [NUM_PAT-1:0] decode(input logic [PAT_LEN-1:0] h,
                                                 input logic [FILL_W-1:0]  f);
      logic [NUM_PAT-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_PAT; i++)
         m[i] = (f == FILL_FULL) && (h == PATTERNS[i*PAT_LEN +: PAT_LEN]);
      return m;
   endfunction

   // Moore outputs, decoded from registered state only.
   always_comb begin
      match_vec = decode(hist, fill);
      y         = |match_vec;
   end

   // Next-state logic: clear, sample or hold; counter bumps when the new
   // window matches any pattern.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      hist_nxt = hist;
      fill_nxt = fill;
      cnt_nxt  = match_cnt;
      if (clr) begin
         hist_nxt = '0;
         fill_nxt = '0;
         cnt_nxt  = '0;
      end else if (x_valid) begin
         hist_nxt = {hist[PAT_LEN-2:0], x};
         if (!overlap && y)
            fill_nxt = FILL_ONE;
         else if (fill != FILL_FULL)
            fill_nxt = fill + FILL_ONE;
         if ((|decode(hist_nxt, fill_nxt)) && (match_cnt != CNT_MAX))
            cnt_nxt = match_cnt + CNT_W'(1);
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (!rst) begin
         hist      <= '0;
         fill      <= '0;
         match_cnt <= '0;
      end else begin
         hist      <= hist_nxt;
         fill      <= fill_nxt;
         match_cnt <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: directed steps push the
// hand-computed post-edge state into a queue; a monitor pops and compares
// one entry shortly after each rising edge.
module tb_seq_pattern_detector;

   logic clk = 1'b0;
   logic rst = 1'b0;

   // Instance 1: default parameters (patterns 001 and 110).
   logic       x1 = 1'b0, xv1 = 1'b0, ov1 = 1'b1, clr1 = 1'b0;
   logic       y1;
   logic [1:0] mv1;
   logic [7:0] cnt1;
   logic [2:0] hist1;
   logic [1:0] fill1;

   // Instance 2: PAT_LEN=4, single pattern 0000, 2-bit counter.
   logic       x2 = 1'b0, xv2 = 1'b0, ov2 = 1'b1, clr2 = 1'b0;
   logic       y2;
   logic [0:0] mv2;
   logic [1:0] cnt2;
   logic [3:0] hist2;
   logic [2:0] fill2;

   seq_pattern_detector dut1 (
      .clk(clk), .rst(rst), .x(x1), .x_valid(xv1), .overlap(ov1), .clr(clr1),
      .y(y1), .match_vec(mv1), .match_cnt(cnt1), .hist(hist1), .fill(fill1)
   );

   seq_pattern_detector #(
      .PAT_LEN(4), .NUM_PAT(1), .PATTERNS(4'b0000), .CNT_W(2)
   ) dut2 (
      .clk(clk), .rst(rst), .x(x2), .x_valid(xv2), .overlap(ov2), .clr(clr2),
      .y(y2), .match_vec(mv2), .match_cnt(cnt2), .hist(hist2), .fill(fill2)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         which;
      string      tag;
      logic       y;
      logic [1:0] mv;
      int         cnt;
      logic [3:0] hist;
      int         fill;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: the DUT presents a new state after every edge; compare it
   // against the oldest expectation, if any is pending.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (e.which == 1) begin
            check({e.tag, ".y"},    32'(y1),    32'(e.y));
            check({e.tag, ".mv"},   32'(mv1),   32'(e.mv));
            check({e.tag, ".cnt"},  32'(cnt1),  32'(e.cnt));
            check({e.tag, ".hist"}, 32'(hist1), 32'(e.hist));
            check({e.tag, ".fill"}, 32'(fill1), 32'(e.fill));
         end else begin
            check({e.tag, ".y"},    32'(y2),    32'(e.y));
            check({e.tag, ".mv"},   32'(mv2),   32'(e.mv));
            check({e.tag, ".cnt"},  32'(cnt2),  32'(e.cnt));
            check({e.tag, ".hist"}, 32'(hist2), 32'(e.hist));
            check({e.tag, ".fill"}, 32'(fill2), 32'(e.fill));
         end
      end
   end

   // Drive one edge's inputs at the falling edge and queue the expected
   // state after the following rising edge.
   task automatic step(input int which, input logic xi, input logic xvi,
                       input logic ovi, input logic clri, input string tag,
                       input logic ey, input logic [1:0] emv, input int ecnt,
                       input logic [3:0] eh, input int ef);
      exp_t e;
      @(negedge clk);
      if (which == 1) begin
         x1 = xi; xv1 = xvi; ov1 = ovi; clr1 = clri;
      end else begin
         x2 = xi; xv2 = xvi; ov2 = ovi; clr2 = clri;
      end
      e.which = which; e.tag = tag; e.y = ey; e.mv = emv;
      e.cnt = ecnt; e.hist = eh; e.fill = ef;
      q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, asserted from time zero.
      #2;
      check("rst.y", 32'(y1), 32'(0));
      check("rst.cnt", 32'(cnt1), 32'(0));
      check("rst.fill", 32'(fill1), 32'(0));
      @(negedge clk); rst = 1'b1;

      // Overlapping, stream 0,0,1,1,0,0,1,1.
      step(1, 0, 1, 1, 0, "ov1", 0, 2'b00, 0, 4'b000, 1);
      step(1, 0, 1, 1, 0, "ov2", 0, 2'b00, 0, 4'b000, 2);
      step(1, 1, 1, 1, 0, "ov3", 1, 2'b01, 1, 4'b001, 3);
      step(1, 1, 1, 1, 0, "ov4", 0, 2'b00, 1, 4'b011, 3);
      step(1, 0, 1, 1, 0, "ov5", 1, 2'b10, 2, 4'b110, 3);
      step(1, 0, 1, 1, 0, "ov6", 0, 2'b00, 2, 4'b100, 3);
      step(1, 1, 1, 1, 0, "ov7", 1, 2'b01, 3, 4'b001, 3);
      step(1, 1, 1, 1, 0, "ov8", 0, 2'b00, 3, 4'b011, 3);

      // Clear, then the same stream non-overlapping.
      step(1, 0, 0, 0, 1, "clrA", 0, 2'b00, 0, 4'b000, 0);
      step(1, 0, 1, 0, 0, "no1", 0, 2'b00, 0, 4'b000, 1);
      step(1, 0, 1, 0, 0, "no2", 0, 2'b00, 0, 4'b000, 2);
      step(1, 1, 1, 0, 0, "no3", 1, 2'b01, 1, 4'b001, 3);
      step(1, 1, 1, 0, 0, "no4", 0, 2'b00, 1, 4'b011, 1);
      step(1, 0, 1, 0, 0, "no5", 0, 2'b00, 1, 4'b110, 2);
      step(1, 0, 1, 0, 0, "no6", 0, 2'b00, 1, 4'b100, 3);
      step(1, 1, 1, 0, 0, "no7", 1, 2'b01, 2, 4'b001, 3);
      step(1, 1, 1, 0, 0, "no8", 0, 2'b00, 2, 4'b011, 1);

      // Hold: four invalid cycles right after a 001 match.
      step(1, 0, 0, 1, 1, "clrB", 0, 2'b00, 0, 4'b000, 0);
      step(1, 0, 1, 1, 0, "h1", 0, 2'b00, 0, 4'b000, 1);
      step(1, 0, 1, 1, 0, "h2", 0, 2'b00, 0, 4'b000, 2);
      step(1, 1, 1, 1, 0, "h3", 1, 2'b01, 1, 4'b001, 3);
      step(1, 0, 0, 1, 0, "hold1", 1, 2'b01, 1, 4'b001, 3);
      step(1, 1, 0, 0, 0, "hold2", 1, 2'b01, 1, 4'b001, 3);
      step(1, 0, 0, 1, 0, "hold3", 1, 2'b01, 1, 4'b001, 3);
      step(1, 1, 0, 1, 0, "hold4", 1, 2'b01, 1, 4'b001, 3);
      step(1, 1, 1, 1, 0, "resume", 0, 2'b00, 1, 4'b011, 3);

      // Build match_cnt up to 5, then clr together with a valid 1.
      step(1, 0, 1, 1, 0, "c2", 1, 2'b10, 2, 4'b110, 3);
      step(1, 0, 1, 1, 0, "c2b", 0, 2'b00, 2, 4'b100, 3);
      step(1, 1, 1, 1, 0, "c3", 1, 2'b01, 3, 4'b001, 3);
      step(1, 1, 1, 1, 0, "c3b", 0, 2'b00, 3, 4'b011, 3);
      step(1, 0, 1, 1, 0, "c4", 1, 2'b10, 4, 4'b110, 3);
      step(1, 0, 1, 1, 0, "c4b", 0, 2'b00, 4, 4'b100, 3);
      step(1, 1, 1, 1, 0, "c5", 1, 2'b01, 5, 4'b001, 3);
      step(1, 1, 1, 1, 1, "clrwin", 0, 2'b00, 0, 4'b000, 0);

      // Asynchronous reset mid-stream while y=1.
      step(1, 0, 1, 1, 0, "r1", 0, 2'b00, 0, 4'b000, 1);
      step(1, 0, 1, 1, 0, "r2", 0, 2'b00, 0, 4'b000, 2);
      step(1, 1, 1, 1, 0, "r3", 1, 2'b01, 1, 4'b001, 3);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst.y", 32'(y1), 32'(0));
      check("arst.mv", 32'(mv1), 32'(0));
      check("arst.cnt", 32'(cnt1), 32'(0));
      check("arst.hist", 32'(hist1), 32'(0));
      check("arst.fill", 32'(fill1), 32'(0));
      // Edge while still in reset with a valid 1: nothing sampled.
      step(1, 1, 1, 1, 0, "inrst", 0, 2'b00, 0, 4'b000, 0);
      @(negedge clk);
      rst = 1'b1; xv1 = 1'b0;
      step(1, 0, 1, 1, 0, "p1", 0, 2'b00, 0, 4'b000, 1);
      step(1, 0, 1, 1, 0, "p2", 0, 2'b00, 0, 4'b000, 2);
      step(1, 1, 1, 1, 0, "p3", 1, 2'b01, 1, 4'b001, 3);
      step(1, 1, 0, 1, 0, "p4", 1, 2'b01, 1, 4'b001, 3);

      // Instance 2: all-zero pattern, seven zeros, counter saturates at 3.
      step(2, 0, 1, 1, 0, "z1", 0, 2'b00, 0, 4'b0000, 1);
      step(2, 0, 1, 1, 0, "z2", 0, 2'b00, 0, 4'b0000, 2);
      step(2, 0, 1, 1, 0, "z3", 0, 2'b00, 0, 4'b0000, 3);
      step(2, 0, 1, 1, 0, "z4", 1, 2'b01, 1, 4'b0000, 4);
      step(2, 0, 1, 1, 0, "z5", 1, 2'b01, 2, 4'b0000, 4);
      step(2, 0, 1, 1, 0, "z6", 1, 2'b01, 3, 4'b0000, 4);
      step(2, 0, 1, 1, 0, "z7", 1, 2'b01, 3, 4'b0000, 4);
      step(2, 0, 0, 1, 0, "zh", 1, 2'b01, 3, 4'b0000, 4);

      repeat (3) @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
